// File: rtl/burst_len_logger.sv
// burst_len_logger: counts beats per burst and queues burst lengths in a small FIFO.
// Define BURST_LEN_SAT_EN to saturate the beat counter instead of letting it wrap.
module burst_len_logger #(
   parameter int CNT_W = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s,
   input  logic             g,
   output logic [CNT_W-1:0] len_data,
   output logic             len_valid,
   input  logic             len_ready,
   output logic             ovf,
   output logic [7:0]       drop_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] ACC  = 1'b1;
   localparam logic [CNT_W+1:0] MAXV = {2'b00, {CNT_W{1'b1}}};
   logic [0:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wp, r_rp;
   logic [AW:0]      r_occ;
   logic             r_ovf;
   logic [7:0]       r_drop;
   logic [CNT_W+1:0] w_inc, w_sum;
   logic [CNT_W-1:0] w_inc_c, w_len;
   logic             w_push, w_pop, w_full, w_wr, w_drop;
   assign w_inc = {2'b00, r_cnt} + {{(CNT_W+1){1'b0}}, 1'b1};
   // a continue beat arriving with the end pulse still belongs to this burst
   assign w_sum = w_inc + {{(CNT_W+1){1'b0}}, s};
`ifdef BURST_LEN_SAT_EN
   assign w_inc_c = (w_inc > MAXV) ? MAXV[CNT_W-1:0] : w_inc[CNT_W-1:0];
   assign w_len   = (w_sum > MAXV) ? MAXV[CNT_W-1:0] : w_sum[CNT_W-1:0];
`else
   assign w_inc_c = w_inc[CNT_W-1:0];
   assign w_len   = w_sum[CNT_W-1:0];
`endif
   assign w_push    = (r_state == ACC) ? g : (g && !s);
   assign len_valid = (r_occ != '0);
   assign len_data  = len_valid ? r_mem[r_rp] : '0;
   assign w_pop     = len_valid && len_ready;
   assign w_full    = (r_occ == (AW+1)'(DEPTH));
   assign w_wr      = w_push && (!w_full || w_pop);
   assign w_drop    = w_push && w_full && !w_pop;
   assign ovf       = r_ovf;
   assign drop_cnt  = r_drop;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else if (r_state == ACC && g) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else if (s) begin
         r_state <= ACC;
         r_cnt   <= w_inc_c;
      end
   end
   always_ff @(posedge clk) begin
      if (w_wr && !rst) r_mem[r_wp] <= w_len;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wp   <= '0;
         r_rp   <= '0;
         r_occ  <= '0;
         r_ovf  <= 1'b0;
         r_drop <= '0;
      end else begin
         if (w_wr) r_wp <= r_wp + 1'b1;
         if (w_pop) r_rp <= r_rp + 1'b1;
         if (w_wr && !w_pop) r_occ <= r_occ + 1'b1;
         else if (!w_wr && w_pop) r_occ <= r_occ - 1'b1;
         r_ovf  <= w_drop;
         r_drop <= (w_drop && r_drop != 8'hFF) ? r_drop + 8'd1 : r_drop;
      end
   end
endmodule

// File: tb/tb_burst_len_logger.sv
// tb_burst_len_logger: directed checks of burst length logging, FIFO order, overflow and reset.
module tb_burst_len_logger;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       s = 1'b0;
   logic       g = 1'b0;
   logic       len_ready = 1'b0;
   logic [7:0] len_data;
   logic       len_valid, ovf;
   logic [7:0] drop_cnt;
   logic [3:0] len_data4;
   logic       len_valid4, ovf4;
   logic [7:0] drop_cnt4;
   int n_pass = 0;
   int n_total = 0;
   burst_len_logger #(.CNT_W(8), .DEPTH(4)) u_dut (
      .clk(clk), .rst(rst), .s(s), .g(g), .len_data(len_data), .len_valid(len_valid),
      .len_ready(len_ready), .ovf(ovf), .drop_cnt(drop_cnt)
   );
   burst_len_logger #(.CNT_W(4), .DEPTH(2)) u_dut4 (
      .clk(clk), .rst(rst), .s(s), .g(g), .len_data(len_data4), .len_valid(len_valid4),
      .len_ready(len_ready), .ovf(ovf4), .drop_cnt(drop_cnt4)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      assert (act === exp) n_pass++;
      else $error("FAIL %s: got %0d expected %0d", tag, act, exp);
   endtask
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   // L-1 continue beats, then the end pulse with len_ready=rdy on that cycle
   task automatic burst(input int len, input logic rdy);
      for (int i = 0; i < len - 1; i++) begin
         s = 1'b1;
         step();
      end
      s = 1'b0;
      g = 1'b1;
      len_ready = rdy;
      step();
      g = 1'b0;
      len_ready = 1'b0;
   endtask
   task automatic drain(input string tag, input int first, input int last);
      for (int k = first; k <= last; k++) begin
         check({tag, "_valid"}, 32'(len_valid), 32'd1);
         check({tag, "_data"}, 32'(len_data), 32'(k));
         len_ready = 1'b1;
         step();
      end
      len_ready = 1'b0;
      check({tag, "_empty"}, 32'(len_valid), 32'd0);
   endtask
   initial begin
      step();
      step();
      check("rst_valid", 32'(len_valid), 32'd0);
      check("rst_data", 32'(len_data), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      check("rst_drop", 32'(drop_cnt), 32'd0);
      rst = 1'b0;
      step();
      burst(1, 1'b0);
      check("single_valid", 32'(len_valid), 32'd1);
      check("single_data", 32'(len_data), 32'd1);
      len_ready = 1'b1;
      step();
      check("single_pop", 32'(len_valid), 32'd0);
      burst(4, 1'b1);
      len_ready = 1'b1;
      check("b4_valid", 32'(len_valid), 32'd1);
      check("b4_data", 32'(len_data), 32'd4);
      step();
      len_ready = 1'b0;
      check("b4_gone", 32'(len_valid), 32'd0);
      for (int l = 2; l <= 5; l++) begin
         burst(l, 1'b0);
         check("fill_noovf", 32'(ovf), 32'd0);
      end
      check("hold_head", 32'(len_data), 32'd2);
      step();
      check("hold_head2", 32'(len_data), 32'd2);
      burst(6, 1'b0);
      check("full_ovf", 32'(ovf), 32'd1);
      check("full_drop", 32'(drop_cnt), 32'd1);
      step();
      check("ovf_pulse_end", 32'(ovf), 32'd0);
      drain("drain1", 2, 5);
      for (int l = 7; l <= 10; l++) burst(l, 1'b0);
      burst(11, 1'b1);
      check("pushpop_full_ovf", 32'(ovf), 32'd0);
      check("pushpop_full_drop", 32'(drop_cnt), 32'd1);
      drain("drain2", 8, 11);
      s = 1'b1;
      step();
      step();
      s = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midrst_empty", 32'(len_valid), 32'd0);
      check("midrst_drop", 32'(drop_cnt), 32'd0);
      burst(1, 1'b0);
      check("midrst_len", 32'(len_data), 32'd1);
      burst(2, 1'b1);
      check("one_pushpop_valid", 32'(len_valid), 32'd1);
      check("one_pushpop_data", 32'(len_data), 32'd2);
      g = 1'b1;
      rst = 1'b1;
      len_ready = 1'b1;
      step();
      g = 1'b0;
      rst = 1'b0;
      len_ready = 1'b0;
      check("rst_prio", 32'(len_valid), 32'd0);
      burst(21, 1'b0);
      check("wide_len", 32'(len_data), 32'd21);
      check("narrow_valid", 32'(len_valid4), 32'd1);
`ifdef BURST_LEN_SAT_EN
      check("narrow_len", 32'(len_data4), 32'd15);
`else
      check("narrow_len", 32'(len_data4), 32'd5);
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
